// File: rtl/hoene_led_pkg.sv
// Shared constants and helpers for the LED PWM array.
package hoene_led_pkg;

  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned MAX_WIDTH    = 16;
  localparam int unsigned MAX_BUS      = MAX_CHANNELS * MAX_WIDTH;

  // Prescaler counter width: $clog2(prescale), never narrower than one bit.
  function automatic int unsigned psc_width(input int unsigned prescale);
    int unsigned w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

  // Extract channel idx (width bits) from a packed duty bus.
  function automatic logic [MAX_WIDTH-1:0] duty_slice(input logic [MAX_BUS-1:0] bus,
                                                      input int unsigned idx,
                                                      input int unsigned width);
    logic [MAX_BUS-1:0]   shifted;
    logic [MAX_WIDTH-1:0] mask;
    shifted = bus >> (idx * width);
    mask    = MAX_WIDTH'((33'd1 << width) - 33'd1);
    return MAX_WIDTH'(shifted) & mask;
  endfunction

endpackage

// File: rtl/tt_um_hoene_led_pwm_channel.sv
// One PWM channel: duty/phase compare with a registered output.
module tt_um_hoene_led_pwm_channel #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] active_i,
  input  logic [WIDTH-1:0] phase_i,
  output logic             pwm_o
);

  logic raw_c;
  logic pwm_q;

  // All-ones duty is full-on rather than one tick short of it.
  always_comb begin
    raw_c = 1'b0;
    if (active_i == '1) raw_c = 1'b1;
    else                raw_c = (phase_i < active_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= enable_i & raw_c;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/tt_um_hoene_led_pwm_array.sv
// Multi-channel LED PWM with shared prescaled period counter and
// double-buffered duty values committed at the period boundary.
module tt_um_hoene_led_pwm_array
  import hoene_led_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned STAGGER  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      pending
);

  localparam int unsigned PSC_W = psc_width(PRESCALE);
  localparam int unsigned BUS_W = CHANNELS * WIDTH;

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0] shadow_q, shadow_d;
  logic [BUS_W-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             period_start_q;
  logic             tick_c;
  logic             wrap_c;

  assign tick_c = (psc_q == PSC_W'(PRESCALE - 1));
  assign wrap_c = enable && tick_c && (cnt_q == '1);

  // Next-state for counters and duty buffers.
  always_comb begin
    psc_d     = psc_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (!enable) begin
      psc_d = '0;
      cnt_d = '0;
    end else if (tick_c) begin
      psc_d = '0;
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end

    if (load) shadow_d = duty_in;

    // Disabled: commit as soon as something is pending.
    if (!enable) begin
      if (pending_q) active_d = shadow_q;
      pending_d = load;
    end else if (wrap_c) begin
      active_d  = load ? duty_in : shadow_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q          <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      psc_q          <= psc_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      period_start_q <= wrap_c;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'(i * STAGGER);
    logic [WIDTH-1:0] duty_c;
    logic [WIDTH-1:0] phase_c;

    assign duty_c  = WIDTH'(duty_slice(MAX_BUS'(active_q), i, WIDTH));
    assign phase_c = cnt_q + OFFSET;

    tt_um_hoene_led_pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable),
      .active_i (duty_c),
      .phase_i  (phase_c),
      .pwm_o    (pwm_out[i])
    );
  end

  assign period_start = period_start_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_tt_um_hoene_led_pwm_array.sv
// Bench for the LED PWM array: three configurations share one stimulus stream.
module tb_tt_um_hoene_led_pwm_array;

  localparam int NI = 3;
  localparam int PSV [NI] = '{1, 4, 1};
  localparam int STV [NI] = '{0, 0, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [11:0] duty_in = 12'h000;
  logic [2:0]  pwm [NI];
  logic        ps [NI];
  logic        pend [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  tt_um_hoene_led_pwm_array #(.CHANNELS(3), .WIDTH(4), .PRESCALE(1), .STAGGER(0)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .duty_in(duty_in),
    .pwm_out(pwm[0]), .period_start(ps[0]), .pending(pend[0]));
  tt_um_hoene_led_pwm_array #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4), .STAGGER(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .duty_in(duty_in),
    .pwm_out(pwm[1]), .period_start(ps[1]), .pending(pend[1]));
  tt_um_hoene_led_pwm_array #(.CHANNELS(3), .WIDTH(4), .PRESCALE(1), .STAGGER(4)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .duty_in(duty_in),
    .pwm_out(pwm[2]), .period_start(ps[2]), .pending(pend[2]));

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: n counts enabled clocks; cnt = floor(n / prescale) mod 16.
  int       m_n   [NI];
  int       m_sh  [NI][3];
  int       m_act [NI][3];
  bit       m_pend[NI];
  bit [2:0] e_pwm [NI];
  bit       e_ps  [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_n[k] = 0; m_pend[k] = 1'b0; e_pwm[k] = 3'b000; e_ps[k] = 1'b0;
        for (int c = 0; c < 3; c++) begin m_sh[k][c] = 0; m_act[k][c] = 0; end
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int  cnt;
        int  ph;
        int  dv [3];
        bit  wrap;
        cnt  = (m_n[k] / PSV[k]) % 16;
        wrap = enable && ((m_n[k] % PSV[k]) == PSV[k] - 1) && (cnt == 15);
        for (int c = 0; c < 3; c++) begin
          dv[c] = int'(duty_in[c*4 +: 4]);
          ph    = (cnt + c * STV[k]) % 16;
          e_pwm[k][c] = enable && ((m_act[k][c] == 15) || (ph < m_act[k][c]));
        end
        e_ps[k] = wrap;
        m_n[k]  = enable ? (m_n[k] + 1) % (16 * PSV[k]) : 0;
        if (!enable) begin
          if (m_pend[k]) for (int c = 0; c < 3; c++) m_act[k][c] = m_sh[k][c];
          m_pend[k] = load;
        end else if (wrap) begin
          for (int c = 0; c < 3; c++) m_act[k][c] = load ? dv[c] : m_sh[k][c];
          m_pend[k] = 1'b0;
        end else if (load) begin
          m_pend[k] = 1'b1;
        end
        if (load) for (int c = 0; c < 3; c++) m_sh[k][c] = dv[c];
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("cyc_pwm%0d", k), int'(pwm[k]), int'(e_pwm[k]));
        chk($sformatf("cyc_ps%0d", k), int'(ps[k]), int'(e_ps[k]));
        chk($sformatf("cyc_pend%0d", k), int'(pend[k]), int'(m_pend[k]));
      end
    end
  end

  int        hi [3];
  int        ps_n;
  bit        ps_last;
  bit [63:0] patt [3];
  bit [63:0] pend_patt;

  task automatic wait_ps(input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (ps[k]) got = 1'b1;
    end
    chk($sformatf("wait_ps%0d", k), int'(got), 1);
  endtask

  // Sample len cycles of instance k; optionally pulse load at sample load_at.
  task automatic measure(input int k, input int len, input int load_at, input logic [11:0] lv);
    ps_n = 0; ps_last = 1'b0; pend_patt = '0;
    for (int c = 0; c < 3; c++) begin hi[c] = 0; patt[c] = '0; end
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++)
        if (pwm[k][c]) begin hi[c]++; patt[c][i-1] = 1'b1; end
      if (ps[k]) ps_n++;
      if (pend[k]) pend_patt[i-1] = 1'b1;
      ps_last = ps[k];
      load = (i == load_at);
      if (i == load_at) duty_in = lv;
    end
    load = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm[0]), 0);
    chk("rst_ps", int'(ps[0]), 0);
    chk("rst_pend", int'(pend[0]), 0);
    rst_n = 1'b1;

    // Duties {0,5,15}
    @(negedge clk);
    enable = 1'b1; load = 1'b1; duty_in = 12'hF50;
    @(negedge clk);
    load = 1'b0;
    chk("t1_pending", int'(pend[0]), 1);
    wait_ps(0);
    measure(0, 16, 0, 12'h000);
    chk("t1_ch0_hi", hi[0], 0);
    chk("t1_ch1_hi", hi[1], 5);
    chk("t1_ch2_hi", hi[2], 16);
    chk("t1_ch1_patt", int'(patt[1][15:0]), 32'h001F);
    chk("t1_ps_n", ps_n, 1);
    chk("t1_ps_last", int'(ps_last), 1);

    // Mid-period load of 9 at cnt=7
    measure(0, 16, 7, 12'hF90);
    chk("t2_old_hi", hi[1], 5);
    chk("t2_pend_patt", int'(pend_patt[15:0]), 32'h7F80);
    chk("t2_ps_last", int'(ps_last), 1);
    measure(0, 16, 0, 12'h000);
    chk("t2_new_hi", hi[1], 9);
    chk("t2_new_patt", int'(patt[1][15:0]), 32'h01FF);

    // Load exactly in the wrap cycle
    measure(0, 16, 15, 12'hF30);
    chk("t3_prev_hi", hi[1], 9);
    chk("t3_pend_none", int'(pend_patt[15:0]), 0);
    measure(0, 16, 0, 12'h000);
    chk("t3_hi", hi[1], 3);
    chk("t3_pend_none2", int'(pend_patt[15:0]), 0);

    // Prescale 4 and stagger 4 with duty 8
    @(negedge clk);
    load = 1'b1; duty_in = 12'h888;
    @(negedge clk);
    load = 1'b0;
    wait_ps(1);
    measure(1, 64, 0, 12'h000);
    for (int c = 0; c < 3; c++) chk($sformatf("t4_hi%0d", c), hi[c], 32);
    chk("t4_patt", int'(patt[0] == 64'h0000_0000_FFFF_FFFF), 1);
    chk("t4_ps_n", ps_n, 1);
    chk("t4_ps_last", int'(ps_last), 1);
    wait_ps(2);
    measure(2, 16, 0, 12'h000);
    chk("t5_ch0_patt", int'(patt[0][15:0]), 32'h00FF);
    chk("t5_ch1_patt", int'(patt[1][15:0]), 32'hF00F);
    chk("t5_ch2_patt", int'(patt[2][15:0]), 32'hFF00);
    for (int c = 0; c < 3; c++) chk($sformatf("t5_hi%0d", c), hi[c], 8);

    // Disabled load commits immediately
    @(negedge clk);
    enable = 1'b0; load = 1'b1; duty_in = 12'hCCC;
    @(negedge clk);
    load = 1'b0;
    chk("t6_pend_set", int'(pend[0]), 1);
    @(negedge clk);
    chk("t6_pend_clr", int'(pend[0]), 0);
    chk("t6_dis_pwm", int'(pwm[0]), 0);
    chk("t6_dis_ps", int'(ps[0]), 0);
    enable = 1'b1;
    measure(0, 16, 0, 12'h000);
    chk("t6_hi1", hi[1], 12);
    chk("t6_patt0", int'(patt[0][15:0]), 32'h0FFF);
    chk("t6_ps_last", int'(ps_last), 1);

    // Asynchronous reset mid-period
    repeat (5) @(negedge clk);
    chk("t6_pre_rst", int'(pwm[0]), 7);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("t6_arst_pwm%0d", k), int'(pwm[k]), 0);
      chk($sformatf("t6_arst_pend%0d", k), int'(pend[k]), 0);
      chk($sformatf("t6_arst_ps%0d", k), int'(ps[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    measure(0, 16, 0, 12'h000);
    for (int c = 0; c < 3; c++) chk($sformatf("t6_post_hi%0d", c), hi[c], 0);
    chk("t6_post_ps_n", ps_n, 1);
    chk("t6_post_ps_last", int'(ps_last), 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_hoene_led_pwm_array.md
Name: tt_um_hoene_led_pwm_array

Overview:
Parametrised successor to the fixed 3×10-bit LED PWM. Drives CHANNELS PWM outputs from one shared period counter with a programmable clock prescaler. Duty values are double-buffered: a shadow register is committed only at the period boundary, so outputs never glitch. An optional per-channel phase stagger spreads switching edges. Sits after serial2parallel and takes the decoded colour words.

Parameters:
CHANNELS, 3, number of PWM outputs (1..8)
WIDTH, 10, duty and period-counter width in bits; period = 2^WIDTH ticks
PRESCALE, 1, system clocks per PWM tick (1..256); 1 = tick every clock
STAGGER, 0, phase offset per channel in ticks; channel i compares against (cnt + i*STAGGER) mod 2^WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = PWM running; 0 = counters held at 0, outputs low
load  in  1  single-cycle strobe: capture duty_in into shadow
duty_in  in  CHANNELS*WIDTH  channel i = duty_in[i*WIDTH +: WIDTH]
pwm_out  out  CHANNELS  registered PWM outputs
period_start  out  1  one-clock pulse on each period wrap
pending  out  1  shadow holds data not yet committed

Behaviour:
- Reset (async, rst_n=0): prescaler=0, cnt=0, shadow=0, active=0, pending=0, pwm_out=0, period_start=0. Reset mid-period aborts immediately.
- Prescaler counts 0..PRESCALE-1. tick=1 when it equals PRESCALE-1, then it returns to 0. With PRESCALE=1, tick is always 1.
- cnt (WIDTH bits) increments on tick. wrap = tick && cnt==2^WIDTH-1, after which cnt becomes 0.
- load=1: shadow<=duty_in and pending<=1. Back-to-back loads overwrite; the last one wins.
- Commit on wrap: active<=shadow, pending<=0.
- load and wrap in the same cycle: active<=duty_in directly, shadow<=duty_in, pending stays 0.
- enable=0:
  - prescaler and cnt are synchronously held at 0; pwm_out=0; period_start=0.
  - load still writes shadow.
  - If pending=1 while disabled, active<=shadow on that cycle and pending<=0. While disabled, commit is immediate.
- enable 0->1: counting starts from cnt=0 with the already-committed active values.
- Compare per channel: phase_i = (cnt + i*STAGGER) mod 2^WIDTH.
  - raw_i = (active_i == all-ones) ? 1 : (phase_i < active_i).
  - duty 0 gives constant low. All-ones gives constant high (deliberate full-on).
  - Any other duty d is high for d of every 2^WIDTH ticks.
- pwm_out_i <= raw_i registered, so outputs trail cnt by 1 clock. period_start is registered from wrap, with the same 1-clock latency.
- Width arithmetic: i*STAGGER is truncated to WIDTH bits at elaboration; addition is modulo 2^WIDTH.

Decomposition:
- Shared package hoene_led_pkg holds:
  - the duty slice helper function;
  - the MAX_CHANNELS=8 constant;
  - a localparam for the prescaler width, $clog2(PRESCALE) (min 1).
- One sub-module, tt_um_hoene_led_pwm_channel, instantiated CHANNELS times via generate. Its ports are active duty, phase and enable; it contains the compare logic and the output flop.
- The prescaler, counter, shadow/active registers and pending flag live in the top.

Test Plan:
1. CHANNELS=3, WIDTH=4, PRESCALE=1, STAGGER=0, enable=1, load duty={0,5,15} -> after the first wrap: ch0 constant 0, ch1 high exactly 5 of 16 clocks starting 1 clk after cnt=0, ch2 constant 1; period_start pulses every 16 clks.
2. Load 5, then load 9 mid-period (cnt=7) -> ch1 keeps duty 5 until the wrap; pending=1 from the load until the wrap; the next period is high 9 clks.
3. Assert load in the exact wrap cycle with duty 3 -> the following period is already duty 3; pending never rises.
4. PRESCALE=4, WIDTH=4, duty 8 -> period = 64 clks, high for 32 clks; period_start spacing is 64.
5. STAGGER=4, all duties 8 -> ch1 rising edge 4 ticks before ch0, ch2 8 ticks before; each stays high 8 ticks.
6. enable=0 with load 12, then enable=1 -> active=12 immediately and pending=0. Then pull rst_n low mid-period -> all outputs 0 asynchronously, and after release cnt restarts at 0 with active=0.
